// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: FSM encoding, MEM/WB bundle and an
// alignment helper used by the access-control FSM.
package memory_stage_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [WORD_W-1:0] read_data;
        logic [WORD_W-1:0] alu_result;
        logic [REG_W-1:0]  rd;
    } mem_wb_t;

    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack port: the MEM stage is the master, the memory the slave.
interface memory_stage_if;
    logic        dmReq;
    logic        dmWe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [31:0] dmRdata;
    logic        dmAck;

    modport master (output dmReq, dmWe, dmAddr, dmWdata, input dmRdata, dmAck);
    modport slave  (input dmReq, dmWe, dmAddr, dmWdata, output dmRdata, dmAck);
endinterface

// File: rtl/memory_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads the next bundle when enabled, and a squash
// kills the register-file write of the bundle being loaded.
module memory_stage_mem_wb_reg
    import memory_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    squash,
    input  mem_wb_t d,
    output mem_wb_t q
);

    mem_wb_t wb_d;
    mem_wb_t wb_q;

    always_comb begin
        wb_d = wb_q;
        if (en) begin
            wb_d = d;
            if (squash) begin
                wb_d.reg_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign q = wb_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: resolves branches, runs load/store over a req/ack memory
// port with a timeout, stalls upstream while busy and feeds the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 valid,
    input  logic [WORD_W-1:0]    aluResult,
    input  logic                 zero,
    input  logic [WORD_W-1:0]    addResult,
    input  logic [WORD_W-1:0]    aluReadData2out,
    input  logic [REG_W-1:0]     rdOrRt,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic                 branch,
    input  logic                 regWrite,
    input  logic                 memToReg,
    memory_stage_if.master       dm,
    output logic                 stall,
    output logic                 pcSrc,
    output logic [WORD_W-1:0]    branchTarget,
    output logic                 wbValid,
    output logic                 wbRegWrite,
    output logic                 wbMemToReg,
    output logic [WORD_W-1:0]    wbReadData,
    output logic [WORD_W-1:0]    wbAluResult,
    output logic [REG_W-1:0]     wbRd,
    output logic                 errMisaligned,
    output logic                 errTimeout
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic [REG_W-1:0]   rd_lat_q, rd_lat_d;
    logic               rw_lat_q, rw_lat_d;
    logic               m2r_lat_q, m2r_lat_d;
    logic               load_lat_q, load_lat_d;
    logic               err_mis_q, err_mis_d;
    logic               err_to_q, err_to_d;

    logic               mem_op;
    logic               wb_en;
    logic               wb_squash;
    mem_wb_t            wb_next;
    mem_wb_t            wb_cur;

    assign mem_op       = valid & (memRead | memWrite);
    assign pcSrc        = valid & branch & zero;
    assign branchTarget = addResult;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_lat_d   = rd_lat_q;
        rw_lat_d   = rw_lat_q;
        m2r_lat_d  = m2r_lat_q;
        load_lat_d = load_lat_q;
        err_mis_d  = err_mis_q;
        err_to_d   = err_to_q;
        stall      = 1'b0;
        wb_en      = 1'b0;
        wb_squash  = 1'b0;
        wb_next    = wb_cur;

        case (state_q)
            ST_IDLE: begin
                wb_en                = 1'b1;
                wb_next.valid        = valid;
                wb_next.reg_write    = regWrite;
                wb_next.mem_to_reg   = memToReg;
                wb_next.alu_result   = aluResult;
                wb_next.rd           = rdOrRt;
                if (mem_op && !is_aligned(aluResult)) begin
                    // Misaligned access retires immediately as a harmless bubble.
                    err_mis_d        = 1'b1;
                    wb_next.valid    = 1'b1;
                    wb_squash        = 1'b1;
                end else if (mem_op) begin
                    stall            = 1'b1;
                    req_d            = 1'b1;
                    we_d             = memWrite;
                    addr_d           = aluResult;
                    wdata_d          = aluReadData2out;
                    rd_lat_d         = rdOrRt;
                    rw_lat_d         = regWrite & ~memWrite;
                    m2r_lat_d        = memToReg;
                    load_lat_d       = ~memWrite;
                    cnt_d            = CNT_W'(1);
                    state_d          = ST_ACCESS;
                    wb_next          = wb_cur;
                    wb_next.valid    = 1'b0;
                end
            end

            ST_ACCESS: begin
                stall = ~dm.dmAck;
                if (dm.dmAck || cnt_q == CNT_W'(TIMEOUT)) begin
                    // Retire: ack takes priority over a coincident timeout.
                    req_d              = 1'b0;
                    we_d               = 1'b0;
                    cnt_d              = '0;
                    state_d            = ST_IDLE;
                    wb_en              = 1'b1;
                    wb_next.valid      = 1'b1;
                    wb_next.reg_write  = rw_lat_q;
                    wb_next.mem_to_reg = m2r_lat_q;
                    wb_next.alu_result = addr_q;
                    wb_next.rd         = rd_lat_q;
                    if (dm.dmAck) begin
                        if (load_lat_q) begin
                            wb_next.read_data = dm.dmRdata;
                        end
                    end else begin
                        err_to_d  = 1'b1;
                        wb_squash = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_lat_q   <= '0;
            rw_lat_q   <= 1'b0;
            m2r_lat_q  <= 1'b0;
            load_lat_q <= 1'b0;
            err_mis_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_lat_q   <= rd_lat_d;
            rw_lat_q   <= rw_lat_d;
            m2r_lat_q  <= m2r_lat_d;
            load_lat_q <= load_lat_d;
            err_mis_q  <= err_mis_d;
            err_to_q   <= err_to_d;
        end
    end

    memory_stage_mem_wb_reg u_mem_wb_reg (
        .clk    (CLK),
        .rst_n  (RST_N),
        .en     (wb_en),
        .squash (wb_squash),
        .d      (wb_next),
        .q      (wb_cur)
    );

    assign dm.dmReq      = req_q;
    assign dm.dmWe       = we_q;
    assign dm.dmAddr     = addr_q;
    assign dm.dmWdata    = wdata_q;

    assign wbValid       = wb_cur.valid;
    assign wbRegWrite    = wb_cur.reg_write;
    assign wbMemToReg    = wb_cur.mem_to_reg;
    assign wbReadData    = wb_cur.read_data;
    assign wbAluResult   = wb_cur.alu_result;
    assign wbRd          = wb_cur.rd;
    assign errMisaligned = err_mis_q;
    assign errTimeout    = err_to_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: a transaction-level model predicts every output each
// cycle for directed and random instructions with a randomly delayed memory.
module tb_memory_stage;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        valid, zero, memRead, memWrite, branch, regWrite, memToReg;
    logic [31:0] aluResult, addResult, aluReadData2out;
    logic [4:0]  rdOrRt;
    logic        stall, pcSrc, wbValid, wbRegWrite, wbMemToReg;
    logic        errMisaligned, errTimeout;
    logic [31:0] branchTarget, wbReadData, wbAluResult;
    logic [4:0]  wbRd;

    memory_stage_if dm ();

    memory_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .valid(valid), .aluResult(aluResult), .zero(zero),
        .addResult(addResult), .aluReadData2out(aluReadData2out), .rdOrRt(rdOrRt),
        .memRead(memRead), .memWrite(memWrite), .branch(branch), .regWrite(regWrite),
        .memToReg(memToReg), .dm(dm), .stall(stall), .pcSrc(pcSrc),
        .branchTarget(branchTarget), .wbValid(wbValid), .wbRegWrite(wbRegWrite),
        .wbMemToReg(wbMemToReg), .wbReadData(wbReadData), .wbAluResult(wbAluResult),
        .wbRd(wbRd), .errMisaligned(errMisaligned), .errTimeout(errTimeout)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Expected outputs, kept by the transaction model.
    logic        e_stall, e_pcsrc, e_req, e_we, e_wbv, e_rw, e_m2r, e_emis, e_eto;
    logic [31:0] e_target, e_addr, e_wdata, e_rdata, e_alu;
    logic [4:0]  e_rd;

    // Values observed during the most recent instruction, for literal checks.
    logic        obs_stall0, obs_pcsrc, obs_we;
    logic [31:0] obs_target, obs_addr, obs_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_stall = 0; e_pcsrc = 0; e_req = 0; e_we = 0; e_wbv = 0; e_rw = 0; e_m2r = 0;
        e_emis = 0; e_eto = 0; e_target = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
        e_alu = 0; e_rd = 0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("pcSrc", 32'(pcSrc), 32'(e_pcsrc));
            chk("branchTarget", branchTarget, e_target);
            chk("dmReq", 32'(dm.dmReq), 32'(e_req));
            if (e_req) begin
                chk("dmWe", 32'(dm.dmWe), 32'(e_we));
                chk("dmAddr", dm.dmAddr, e_addr);
                chk("dmWdata", dm.dmWdata, e_wdata);
            end
            chk("wbValid", 32'(wbValid), 32'(e_wbv));
            if (e_wbv) begin
                chk("wbRegWrite", 32'(wbRegWrite), 32'(e_rw));
                chk("wbMemToReg", 32'(wbMemToReg), 32'(e_m2r));
                chk("wbReadData", wbReadData, e_rdata);
                chk("wbAluResult", wbAluResult, e_alu);
                chk("wbRd", 32'(wbRd), 32'(e_rd));
            end
            chk("errMisaligned", 32'(errMisaligned), 32'(e_emis));
            chk("errTimeout", 32'(errTimeout), 32'(e_eto));
        end
    end

    // One instruction in EX/MEM; lat = ACCESS cycle carrying dmAck (0 = never).
    task automatic run_instr(input logic v, mr, mw, br, z, rw, m2r,
                             input logic [31:0] alu, add, wd, input logic [4:0] rd,
                             input int lat, input logic [31:0] rdat);
        logic memop, store, aligned;
        #1;
        valid = v; memRead = mr; memWrite = mw; branch = br; zero = z;
        regWrite = rw; memToReg = m2r; aluResult = alu; addResult = add;
        aluReadData2out = wd; rdOrRt = rd;
        dm.dmAck = 1'($urandom_range(0, 1));
        dm.dmRdata = $urandom;
        memop   = v & (mr | mw);
        store   = mw;
        aligned = (alu % 4) == 0;
        e_stall  = memop & aligned;
        e_pcsrc  = v & br & z;
        e_target = add;
        @(negedge CLK);
        obs_stall0 = stall; obs_pcsrc = pcSrc; obs_target = branchTarget;
        @(posedge CLK);
        e_m2r = m2r; e_alu = alu; e_rd = rd;
        if (!memop) begin
            e_wbv = v; e_rw = rw;
        end else if (!aligned) begin
            e_emis = 1; e_wbv = 1; e_rw = 0;
        end else begin
            e_req = 1; e_we = store; e_addr = alu; e_wdata = wd; e_wbv = 0;
            for (int n = 1; n <= TIMEOUT; n++) begin
                #1;
                dm.dmAck   = (n == lat);
                dm.dmRdata = (n == lat) ? rdat : $urandom;
                e_stall    = (n != lat);
                @(negedge CLK);
                if (n == 1) begin
                    obs_we = dm.dmWe; obs_addr = dm.dmAddr; obs_wdata = dm.dmWdata;
                end
                @(posedge CLK);
                if (n == lat || n == TIMEOUT) begin
                    e_req = 0; e_wbv = 1;
                    e_m2r = m2r; e_alu = alu; e_rd = rd;
                    if (n == lat) begin
                        e_rw = store ? 1'b0 : rw;
                        if (!store) e_rdata = rdat;
                    end else begin
                        e_rw = 0; e_eto = 1;
                    end
                    break;
                end
            end
        end
    endtask

    initial begin
        logic v, mr, mw, rw, al;
        logic [31:0] a;
        int r, lat;
        RST_N = 0; valid = 0; zero = 0; memRead = 0; memWrite = 0; branch = 0;
        regWrite = 0; memToReg = 0; aluResult = 0; addResult = 0;
        aluReadData2out = 0; rdOrRt = 0; dm.dmAck = 0; dm.dmRdata = 0;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("reset dmReq", 32'(dm.dmReq), 32'd0);
        chk("reset wbValid", 32'(wbValid), 32'd0);
        chk("reset dmAddr", dm.dmAddr, 32'd0);
        chk("reset wbAluResult", wbAluResult, 32'd0);
        chk("reset errs", {30'd0, errMisaligned, errTimeout}, 32'd0);
        @(posedge CLK);
        #1 RST_N = 1;
        @(posedge CLK);
        chk_en = 1;

        // ALU pass-through
        run_instr(1, 0, 0, 0, 0, 1, 0, 32'd9, 0, 0, 5'd3, 0, 0);
        #1;
        chk("alu wbValid", 32'(wbValid), 32'd1);
        chk("alu wbAluResult", wbAluResult, 32'd9);
        chk("alu wbRd", 32'(wbRd), 32'd3);
        chk("alu no stall", 32'(obs_stall0), 32'd0);

        // Load, ack on second ACCESS cycle
        run_instr(1, 1, 0, 0, 0, 1, 1, 32'h10, 0, 0, 5'd7, 2, 32'hCAFE);
        #1;
        chk("load dmAddr", obs_addr, 32'h10);
        chk("load dmWe", 32'(obs_we), 32'd0);
        chk("load wbReadData", wbReadData, 32'hCAFE);
        chk("load wbMemToReg", 32'(wbMemToReg), 32'd1);

        // Store, immediate ack; then the same with memRead also set
        run_instr(1, 0, 1, 0, 0, 0, 0, 32'h20, 0, 32'h55, 5'd0, 1, 32'h1234);
        #1;
        chk("store dmWe", 32'(obs_we), 32'd1);
        chk("store dmWdata", obs_wdata, 32'h55);
        chk("store wbRegWrite", 32'(wbRegWrite), 32'd0);
        chk("store keeps rdata", wbReadData, 32'hCAFE);
        run_instr(1, 1, 1, 0, 0, 0, 0, 32'h20, 0, 32'h55, 5'd0, 1, 32'h9999);
        #1;
        chk("rd+wr is store", 32'(obs_we), 32'd1);
        chk("rd+wr keeps rdata", wbReadData, 32'hCAFE);

        // Branch
        run_instr(1, 0, 0, 1, 1, 0, 0, 32'd0, 32'h40, 0, 5'd0, 0, 0);
        #1;
        chk("branch pcSrc", 32'(obs_pcsrc), 32'd1);
        chk("branch target", obs_target, 32'h40);
        run_instr(1, 0, 0, 1, 0, 0, 0, 32'd0, 32'h40, 0, 5'd0, 0, 0);
        #1;
        chk("branch not taken", 32'(obs_pcsrc), 32'd0);

        // Ack on the last allowed cycle is not a timeout
        run_instr(1, 1, 0, 0, 0, 1, 1, 32'h30, 0, 0, 5'd4, TIMEOUT, 32'hBEEF);
        #1;
        chk("ack16 errTimeout", 32'(errTimeout), 32'd0);
        chk("ack16 wbReadData", wbReadData, 32'hBEEF);

        // Misaligned load
        run_instr(1, 1, 0, 0, 0, 1, 1, 32'h13, 0, 0, 5'd5, 1, 0);
        #1;
        chk("misaligned err", 32'(errMisaligned), 32'd1);
        chk("misaligned dmReq", 32'(dm.dmReq), 32'd0);
        chk("misaligned wbRegWrite", 32'(wbRegWrite), 32'd0);
        chk("misaligned no stall", 32'(obs_stall0), 32'd0);

        // Timeout
        run_instr(1, 1, 0, 0, 0, 1, 1, 32'h50, 0, 0, 5'd6, 0, 0);
        #1;
        chk("timeout err", 32'(errTimeout), 32'd1);
        chk("timeout dmReq", 32'(dm.dmReq), 32'd0);
        chk("timeout wbRegWrite", 32'(wbRegWrite), 32'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom % 8) != 0;
            mr = ($urandom % 3) == 0;
            mw = ($urandom % 4) == 0;
            rw = mw ? 1'b0 : 1'($urandom);
            a  = $urandom;
            al = ($urandom % 6) != 0;
            if (al) a = a & 32'hFFFF_FFFC;
            r = $urandom_range(0, 19);
            if (r < 12)      lat = 1 + (r % 3);
            else if (r < 16) lat = $urandom_range(4, 15);
            else if (r < 18) lat = TIMEOUT;
            else             lat = 0;
            run_instr(v, mr, mw, 1'($urandom), 1'($urandom), rw, 1'($urandom),
                      a, $urandom, $urandom, 5'($urandom), lat, $urandom);
        end

        // Reset in the middle of an access
        #1;
        chk_en = 0;
        valid = 1; memRead = 1; memWrite = 0; branch = 0; aluResult = 32'h44;
        dm.dmAck = 0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        chk("pre-reset dmReq", 32'(dm.dmReq), 32'd1);
        RST_N = 0; valid = 0; memRead = 0;
        #1;
        chk("mid-reset dmReq", 32'(dm.dmReq), 32'd0);
        chk("mid-reset wbValid", 32'(wbValid), 32'd0);
        chk("mid-reset stall", 32'(stall), 32'd0);
        chk("mid-reset errs", {30'd0, errMisaligned, errTimeout}, 32'd0);
        chk("mid-reset dmAddr", dm.dmAddr, 32'd0);
        @(posedge CLK);
        #1 RST_N = 1;
        model_reset();
        @(posedge CLK);
        chk_en = 1;
        run_instr(1, 0, 0, 0, 0, 1, 0, 32'd9, 0, 0, 5'd3, 0, 0);
        #1;
        chk("post-reset idle wbValid", 32'(wbValid), 32'd1);
        chk("post-reset wbAluResult", wbAluResult, 32'd9);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
